peak_bin_analyzer: RTL and testbench

PEAK_BIN_ANALYZER -- requirements
Module: peak_bin_analyzer

---
 rtl/peak_bin_analyzer.sv | 132 +++++++++++++
 tb/tb_peak_bin_analyzer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_bin_analyzer.sv
// Streaming peak-bin finder: per-bin magnitude, then a registered binary
// comparator tree returning the lowest-index maximum bin of every FFT vector.
module peak_bin_analyzer #(
  parameter int NBINS    = 16,
  parameter int HALF_W   = 16,
  parameter int MAG_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fft_valid,
  input  logic [NBINS*2*HALF_W-1:0]   fft_data,
  input  logic [2*HALF_W:0]           threshold,
  output logic                        done,
  output logic [$clog2(NBINS)-1:0]    freq,
  output logic [2*HALF_W:0]           peak_mag,
  output logic                        above_thr
);

  localparam int MAG_W = 2 * HALF_W + 1;
  localparam int IDX_W = $clog2(NBINS);
  localparam int LAT   = 1 + IDX_W;
  localparam int NODES = 2 * NBINS - 1;

  // Handshake: fft_valid is a one-way valid. Every cycle it is high one vector
  // (with its threshold) is taken; there is no ready and the pipe never stalls.

  // Tree storage is a flat array: level l occupies [lvl_off(l), lvl_off(l+1)),
  // level 0 holds the NBINS magnitudes and the root sits at NODES-1.
  function automatic int lvl_off(input int l);
    return 2 * NBINS - ((2 * NBINS) >> l);
  endfunction

  function automatic logic [MAG_W-1:0] bin_mag(input logic [2*HALF_W-1:0] bin);
    logic signed [HALF_W-1:0]   re;
    logic signed [HALF_W-1:0]   im;
    logic signed [2*HALF_W-1:0] re_w;
    logic signed [2*HALF_W-1:0] im_w;
    logic signed [2*HALF_W-1:0] re_sq;
    logic signed [2*HALF_W-1:0] im_sq;
    logic signed [HALF_W:0]     re_x;
    logic signed [HALF_W:0]     im_x;
    logic [HALF_W:0]            re_abs;
    logic [HALF_W:0]            im_abs;
    re    = bin[2*HALF_W-1:HALF_W];
    im    = bin[HALF_W-1:0];
    re_w  = {{HALF_W{re[HALF_W-1]}}, re};
    im_w  = {{HALF_W{im[HALF_W-1]}}, im};
    // Each square is at most 2^(2*HALF_W-2), so it stays positive in 2*HALF_W bits.
    re_sq = re_w * re_w;
    im_sq = im_w * im_w;
    re_x  = {re[HALF_W-1], re};
    im_x  = {im[HALF_W-1], im};
    re_abs = re_x[HALF_W] ? -re_x : re_x;
    im_abs = im_x[HALF_W] ? -im_x : im_x;
    if (MAG_MODE == 0)
      return {1'b0, re_sq} + {1'b0, im_sq};
    else
      return {{(MAG_W-HALF_W-1){1'b0}}, re_abs} + {{(MAG_W-HALF_W-1){1'b0}}, im_abs};
  endfunction

  logic [LAT-1:0]   vld;
  logic [MAG_W-1:0] thr_q    [LAT];
  logic [MAG_W-1:0] node_mag [NODES];
  logic [IDX_W-1:0] node_idx [NODES];
  logic [MAG_W-1:0] win_mag  [NBINS-1];
  logic [IDX_W-1:0] win_idx  [NBINS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else     vld <= {vld[LAT-2:0], fft_valid};
  end

  // Left child always carries the lower indices, so it keeps ties.
  always_comb begin
    for (int n = 0; n < NBINS - 1; n++) begin
      win_mag[n] = '0;
      win_idx[n] = '0;
    end
    for (int l = 1; l <= IDX_W; l++) begin
      for (int j = 0; j < (NBINS >> l); j++) begin
        if (node_mag[lvl_off(l-1)+2*j+1] > node_mag[lvl_off(l-1)+2*j]) begin
          win_mag[lvl_off(l)+j-NBINS] = node_mag[lvl_off(l-1)+2*j+1];
          win_idx[lvl_off(l)+j-NBINS] = node_idx[lvl_off(l-1)+2*j+1];
        end else begin
          win_mag[lvl_off(l)+j-NBINS] = node_mag[lvl_off(l-1)+2*j];
          win_idx[lvl_off(l)+j-NBINS] = node_idx[lvl_off(l-1)+2*j];
        end
      end
    end
  end

  // Datapath registers only move when their stage holds a live vector.
  always_ff @(posedge clk) begin
    if (fft_valid) begin
      thr_q[0] <= threshold;
      for (int k = 0; k < NBINS; k++) begin
        node_mag[k] <= bin_mag(fft_data[k*2*HALF_W +: 2*HALF_W]);
        node_idx[k] <= IDX_W'(k);
      end
    end
    for (int l = 1; l <= IDX_W; l++) begin
      if (vld[l-1]) begin
        thr_q[l] <= thr_q[l-1];
        for (int j = 0; j < (NBINS >> l); j++) begin
          node_mag[lvl_off(l)+j] <= win_mag[lvl_off(l)+j-NBINS];
          node_idx[lvl_off(l)+j] <= win_idx[lvl_off(l)+j-NBINS];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      freq      <= '0;
      peak_mag  <= '0;
      above_thr <= 1'b0;
    end else begin
      done <= vld[IDX_W];
      if (vld[IDX_W]) begin
        freq      <= node_idx[NODES-1];
        peak_mag  <= node_mag[NODES-1];
        above_thr <= (node_mag[NODES-1] >= thr_q[IDX_W]);
      end else begin
        freq      <= '0;
        peak_mag  <= '0;
        above_thr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peak_bin_analyzer.sv
// Directed bench for peak_bin_analyzer: default, |re|+|im|, 2-bin and 64-bin
// instances driven together with hand-computed and modelled expectations.
module tb_peak_bin_analyzer;

  localparam int LAT16 = 5;
  localparam int LAT2  = 2;
  localparam int LAT64 = 7;
  localparam int K     = 40;

  logic         clk;
  logic         rst;
  logic         valid;
  logic [511:0] data16;
  logic [32:0]  thr;
  logic [63:0]  data2;
  logic [32:0]  thr2;
  logic [2047:0] data64;
  logic [32:0]  thr64;

  logic        done_a, above_a, done_b, above_b, done_c, above_c, done_d, above_d;
  logic [3:0]  freq_a, freq_b;
  logic [0:0]  freq_c;
  logic [5:0]  freq_d;
  logic [32:0] peak_a, peak_b, peak_c, peak_d;

  int checks;
  int errors;

  peak_bin_analyzer #(.NBINS(16), .HALF_W(16), .MAG_MODE(0)) u_dut (
    .clk(clk), .rst(rst), .fft_valid(valid), .fft_data(data16), .threshold(thr),
    .done(done_a), .freq(freq_a), .peak_mag(peak_a), .above_thr(above_a));

  peak_bin_analyzer #(.NBINS(16), .HALF_W(16), .MAG_MODE(1)) u_abs (
    .clk(clk), .rst(rst), .fft_valid(valid), .fft_data(data16), .threshold(thr),
    .done(done_b), .freq(freq_b), .peak_mag(peak_b), .above_thr(above_b));

  peak_bin_analyzer #(.NBINS(2), .HALF_W(16), .MAG_MODE(0)) u_n2 (
    .clk(clk), .rst(rst), .fft_valid(valid), .fft_data(data2), .threshold(thr2),
    .done(done_c), .freq(freq_c), .peak_mag(peak_c), .above_thr(above_c));

  peak_bin_analyzer #(.NBINS(64), .HALF_W(16), .MAG_MODE(0)) u_n64 (
    .clk(clk), .rst(rst), .fft_valid(valid), .fft_data(data64), .threshold(thr64),
    .done(done_d), .freq(freq_d), .peak_mag(peak_d), .above_thr(above_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_bin16(input int k, input int re, input int im);
    data16[k*32 +: 32] = {re[15:0], im[15:0]};
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({done_a, freq_a, peak_a, above_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got done=%b freq=%0d peak=%0d above=%b exp all 0",
               done_a, freq_a, peak_a, above_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done_a, done_b, done_c, done_d} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle_done got %b exp 0000", {done_a, done_b, done_c, done_d});
    end
  endtask

  task automatic test_single();
    data16 = '0;
    set_bin16(5, 3, 4);
    thr = 33'd20;
    @(negedge clk);
    valid = 1'b1;
    for (int c = 1; c <= LAT16 + 2; c++) begin
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (done_a !== (c == LAT16 + 1)) begin
        errors++;
        $display("FAIL single_done c=%0d got %b exp %b", c, done_a, c == LAT16 + 1);
      end
      if (c == LAT16 + 1) begin
        checks++;
        if ({freq_a, peak_a, above_a} !== {4'd5, 33'd25, 1'b1}) begin
          errors++;
          $display("FAIL single_result got freq=%0d peak=%0d above=%b exp 5 25 1",
                   freq_a, peak_a, above_a);
        end
        checks++;
        if ({done_b, freq_b, peak_b, above_b} !== {1'b1, 4'd5, 33'd7, 1'b0}) begin
          errors++;
          $display("FAIL single_abs got done=%b freq=%0d peak=%0d above=%b exp 1 5 7 0",
                   done_b, freq_b, peak_b, above_b);
        end
      end else begin
        checks++;
        if ({freq_a, peak_a, above_a} !== '0) begin
          errors++;
          $display("FAIL single_idle_zero c=%0d got freq=%0d peak=%0d above=%b exp 0",
                   c, freq_a, peak_a, above_a);
        end
      end
    end
  endtask

  task automatic test_tie();
    for (int k = 0; k < 16; k++) set_bin16(k, 1, 1);
    set_bin16(2, -7, 0);
    set_bin16(9, -7, 0);
    thr = 33'd49;
    @(negedge clk);
    valid = 1'b1;
    for (int c = 1; c <= LAT16 + 2; c++) begin
      @(negedge clk);
      valid = 1'b0;
      if (c == LAT16 + 1) begin
        checks++;
        if ({done_a, freq_a, peak_a, above_a} !== {1'b1, 4'd2, 33'd49, 1'b1}) begin
          errors++;
          $display("FAIL tie_result got done=%b freq=%0d peak=%0d above=%b exp 1 2 49 1",
                   done_a, freq_a, peak_a, above_a);
        end
        checks++;
        if ({done_b, freq_b, peak_b, above_b} !== {1'b1, 4'd2, 33'd7, 1'b0}) begin
          errors++;
          $display("FAIL tie_abs got done=%b freq=%0d peak=%0d above=%b exp 1 2 7 0",
                   done_b, freq_b, peak_b, above_b);
        end
      end
    end
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 15; k++) set_bin16(k, 32767, 0);
    set_bin16(15, -32768, -32768);
    thr = 33'h0_8000_0000;
    @(negedge clk);
    valid = 1'b1;
    for (int c = 1; c <= LAT16 + 2; c++) begin
      @(negedge clk);
      valid = 1'b0;
      if (c == LAT16 + 1) begin
        checks++;
        if ({done_a, freq_a, peak_a, above_a} !== {1'b1, 4'd15, 33'h0_8000_0000, 1'b1}) begin
          errors++;
          $display("FAIL extremes_sq got done=%b freq=%0d peak=%0d above=%b exp 1 15 2147483648 1",
                   done_a, freq_a, peak_a, above_a);
        end
        checks++;
        if ({done_b, freq_b, peak_b, above_b} !== {1'b1, 4'd15, 33'd65536, 1'b0}) begin
          errors++;
          $display("FAIL extremes_abs got done=%b freq=%0d peak=%0d above=%b exp 1 15 65536 0",
                   done_b, freq_b, peak_b, above_b);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_f [3];
    logic [32:0] exp_m [3];
    int i;
    exp_f = '{4'd0, 4'd15, 4'd7};
    exp_m = '{33'd10000, 33'd2500, 33'd200};
    for (int c = 0; c <= LAT16 + 4; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        i = c - 1 - LAT16;
        checks++;
        if (done_a !== (i >= 0 && i < 3)) begin
          errors++;
          $display("FAIL b2b_done c=%0d got %b exp %b", c, done_a, i >= 0 && i < 3);
        end
        if (i >= 0 && i < 3) begin
          checks++;
          if ({freq_a, peak_a, above_a} !== {exp_f[i], exp_m[i], 1'b0}) begin
            errors++;
            $display("FAIL b2b_result vec=%0d got freq=%0d peak=%0d above=%b exp %0d %0d 0",
                     i, freq_a, peak_a, above_a, exp_f[i], exp_m[i]);
          end
        end
      end
      data16 = '0;
      valid  = (c < 3);
      case (c)
        0: begin set_bin16(0, 100, 0);  thr = 33'd10001; end
        1: begin set_bin16(15, 0, -50); thr = 33'd2501;  end
        2: begin set_bin16(7, 10, 10);  thr = 33'd201;   end
        default: begin
          data16 = {16{$urandom()}};
          thr    = {1'b0, $urandom()};
        end
      endcase
    end
    valid = 1'b0;
  endtask

  task automatic test_async_reset();
    data16 = '0;
    set_bin16(1, 2, 0);
    thr = 33'd0;
    @(negedge clk);
    valid = 1'b1;
    for (int c = 1; c <= LAT16 + 1; c++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    checks++;
    if ({done_a, freq_a, peak_a} !== {1'b1, 4'd1, 33'd4}) begin
      errors++;
      $display("FAIL async_pre got done=%b freq=%0d peak=%0d exp 1 1 4", done_a, freq_a, peak_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({done_a, freq_a, peak_a, above_a} !== '0) begin
      errors++;
      $display("FAIL async_clear got done=%b freq=%0d peak=%0d above=%b exp all 0",
               done_a, freq_a, peak_a, above_a);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL async_after got done=%b exp 0", done_a);
    end
  endtask

  task automatic test_reset_midflight();
    data16 = '0;
    set_bin16(3, 5, 0);
    thr = 33'd0;
    @(negedge clk);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data16 = '0;
    set_bin16(12, 0, 6);
    thr = 33'd36;
    valid = 1'b1;
    for (int c = 1; c <= LAT16 + 3; c++) begin
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (done_a !== (c == LAT16 + 1)) begin
        errors++;
        $display("FAIL midflight_done c=%0d got %b exp %b", c, done_a, c == LAT16 + 1);
      end
      if (c == LAT16 + 1) begin
        checks++;
        if ({freq_a, peak_a, above_a} !== {4'd12, 33'd36, 1'b1}) begin
          errors++;
          $display("FAIL midflight_result got freq=%0d peak=%0d above=%b exp 12 36 1",
                   freq_a, peak_a, above_a);
        end
        checks++;
        if ({freq_b, peak_b, above_b} !== {4'd12, 33'd6, 1'b0}) begin
          errors++;
          $display("FAIL midflight_abs got freq=%0d peak=%0d above=%b exp 12 6 0",
                   freq_b, peak_b, above_b);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic        ev   [K];
    logic [0:0]  e2_f [K];
    logic [32:0] e2_m [K];
    logic        e2_a [K];
    logic [5:0]  e64_f [K];
    logic [32:0] e64_m [K];
    logic        e64_a [K];
    longint best, m, t;
    int bi, re, im, i2, i64;
    for (int c = 0; c <= K + LAT64 + 1; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        i2  = c - 1 - LAT2;
        i64 = c - 1 - LAT64;
        checks++;
        if (done_c !== ((i2 >= 0 && i2 < K) ? ev[i2] : 1'b0)) begin
          errors++;
          $display("FAIL sweep2_done c=%0d got %b", c, done_c);
        end else if (done_c) begin
          checks++;
          if ({freq_c, peak_c, above_c} !== {e2_f[i2], e2_m[i2], e2_a[i2]}) begin
            errors++;
            $display("FAIL sweep2_result vec=%0d got freq=%0d peak=%0d above=%b exp %0d %0d %b",
                     i2, freq_c, peak_c, above_c, e2_f[i2], e2_m[i2], e2_a[i2]);
          end
        end
        checks++;
        if (done_d !== ((i64 >= 0 && i64 < K) ? ev[i64] : 1'b0)) begin
          errors++;
          $display("FAIL sweep64_done c=%0d got %b", c, done_d);
        end else if (done_d) begin
          checks++;
          if ({freq_d, peak_d, above_d} !== {e64_f[i64], e64_m[i64], e64_a[i64]}) begin
            errors++;
            $display("FAIL sweep64_result vec=%0d got freq=%0d peak=%0d above=%b exp %0d %0d %b",
                     i64, freq_d, peak_d, above_d, e64_f[i64], e64_m[i64], e64_a[i64]);
          end
        end else if ({freq_d, peak_d, above_d} !== '0) begin
          errors++;
          $display("FAIL sweep64_idle_zero c=%0d got freq=%0d peak=%0d above=%b exp 0",
                   c, freq_d, peak_d, above_d);
        end
      end
      if (c < K) begin
        ev[c] = ($urandom_range(0, 3) != 0);
        valid = ev[c];
        best = -1; bi = 0;
        for (int k = 0; k < 2; k++) begin
          re = (c % 2 == 0) ? $urandom_range(0, 6) - 3 : $urandom_range(0, 65535) - 32768;
          im = (c % 2 == 0) ? $urandom_range(0, 6) - 3 : $urandom_range(0, 65535) - 32768;
          data2[k*32 +: 32] = {re[15:0], im[15:0]};
          m = longint'(re) * re + longint'(im) * im;
          if (m > best) begin best = m; bi = k; end
        end
        t = best + longint'($urandom_range(0, 2)) - 1;
        if (t < 0) t = 0;
        thr2 = t[32:0];
        e2_f[c] = bi[0:0];
        e2_m[c] = best[32:0];
        e2_a[c] = (best >= t);
        best = -1; bi = 0;
        for (int k = 0; k < 64; k++) begin
          re = (c % 2 == 0) ? $urandom_range(0, 6) - 3 : $urandom_range(0, 65535) - 32768;
          im = (c % 2 == 0) ? $urandom_range(0, 6) - 3 : $urandom_range(0, 65535) - 32768;
          data64[k*32 +: 32] = {re[15:0], im[15:0]};
          m = longint'(re) * re + longint'(im) * im;
          if (m > best) begin best = m; bi = k; end
        end
        t = best + longint'($urandom_range(0, 2)) - 1;
        if (t < 0) t = 0;
        thr64 = t[32:0];
        e64_f[c] = bi[5:0];
        e64_m[c] = best[32:0];
        e64_a[c] = (best >= t);
      end else begin
        valid = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    valid  = 1'b0;
    data16 = '0;
    thr    = '0;
    data2  = '0;
    thr2   = '0;
    data64 = '0;
    thr64  = '0;
    test_reset();
    test_single();
    test_tie();
    test_extremes();
    test_back_to_back();
    test_async_reset();
    test_reset_midflight();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
